// File: rtl/div_pkg.sv
// Shared definitions for the non-restoring divider: FSM encoding, default width
// and the iteration-counter width helper.
package div_pkg;

    localparam int DEF_WIDTH = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_t;

    // Counter only has to reach WIDTH-1 before RUN hands over to FIX.
    function automatic int cnt_width(input int w);
        return (w > 2) ? $clog2(w) : 1;
    endfunction

    localparam int DEF_CNT_W = cnt_width(DEF_WIDTH);

endpackage

// File: rtl/div_addsub.sv
// Shared (W)-bit adder/subtractor: sub inverts operand b and supplies the carry-in.
module div_addsub #(
    parameter int W = 33
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         sub,
    output logic [W-1:0] sum
);

    assign sum = a + (b ^ {W{sub}}) + {{(W-1){1'b0}}, sub};

endmodule

// File: rtl/div_nrd_ctrl.sv
// Sequential unsigned non-restoring divider: one quotient bit per RUN cycle,
// a single FIX cycle for remainder correction, and a one-cycle done pulse.
module div_nrd_ctrl
    import div_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int CNT_W = cnt_width(WIDTH);

    state_t           state;
    logic [WIDTH:0]   r;
    logic [WIDTH:0]   d;
    logic [WIDTH-1:0] q;
    logic [CNT_W-1:0] cnt;

    logic [WIDTH:0]   op_a;
    logic [WIDTH:0]   sum;
    logic             sub;

    // RUN feeds the shifted remainder; FIX adds D back onto the unshifted one.
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        op_a = r;
        sub  = 1'b0;
        if (state == RUN) begin
            op_a = {r[WIDTH-1:0], q[WIDTH-1]};
            sub  = ~r[WIDTH];
        end
    end

    div_addsub #(.W(WIDTH + 1)) u_addsub (
        .a   (op_a),
        .b   (d),
        .sub (sub),
        .sum (sum)
    );

    // NOTE: all state here is updated with non-blocking assignments so every
    // register sees the pre-edge values of the others.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            busy        <= 1'b0;
            done        <= 1'b0;
            div_by_zero <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            r           <= '0;
            q           <= '0;
            d           <= '0;
            cnt         <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        busy <= 1'b1;
                        if (divisor == '0) begin
                            quotient    <= '1;
                            remainder   <= dividend;
                            div_by_zero <= 1'b1;
                            done        <= 1'b1;
                            state       <= DONE;
                        end else begin
                            r           <= '0;
                            q           <= dividend;
                            d           <= {1'b0, divisor};
                            cnt         <= '0;
                            div_by_zero <= 1'b0;
                            state       <= RUN;
                        end
                    end
                end
                RUN: begin
                    r   <= sum;
                    q   <= {q[WIDTH-2:0], ~sum[WIDTH]};
                    cnt <= cnt + CNT_W'(1);
                    if (cnt == CNT_W'(WIDTH - 1)) begin
                        state <= FIX;
                    end
                end
                FIX: begin
                    quotient  <= q;
                    remainder <= r[WIDTH] ? sum[WIDTH-1:0] : r[WIDTH-1:0];
                    r         <= r[WIDTH] ? sum : r;
                    done      <= 1'b1;
                    state     <= DONE;
                end
                DONE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_div_nrd_ctrl.sv
// Scoreboard bench for div_nrd_ctrl: directed vectors push expected results,
// a negedge monitor pops and compares on every done pulse.
module tb_div_nrd_ctrl;

    typedef struct {
        logic [31:0] q;
        logic [31:0] r;
        logic        dbz;
        int          lat;
        int          s;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [31:0] dividend = '0;
    logic [31:0] divisor = '0;
    logic        busy;
    logic        done;
    logic [31:0] quotient;
    logic [31:0] remainder;
    logic        div_by_zero;

    exp_t sb[$];
    exp_t e;
    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc = 0;

    div_nrd_ctrl #(.WIDTH(32)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (!rst && done) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_done: got done=1 at cycle %0d expected no pending op", cyc);
            end else begin
                e = sb.pop_front();
                check("quotient", quotient, e.q);
                check("remainder", remainder, e.r);
                check("div_by_zero", {31'b0, div_by_zero}, {31'b0, e.dbz});
                check("latency", cyc - e.s + 1, e.lat);
            end
        end
    end

    task automatic issue(input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] qe, input logic [31:0] re,
                         input logic dbz, input int lat, input bit expect_result);
        exp_t x;
        @(negedge clk);
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        x = '{qe, re, dbz, lat, cyc + 1};
        if (expect_result) sb.push_back(x);
        @(negedge clk);
        start    = 1'b0;
        dividend = $urandom;
        divisor  = $urandom;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 100; i++) begin
            if (!busy) break;
            @(negedge clk);
        end
        check("idle_reached", {31'b0, busy}, 32'd0);
    endtask

    task automatic div(input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] qe, input logic [31:0] re);
        issue(a, b, qe, re, 1'b0, 34, 1'b1);
        wait_idle();
    endtask

    initial begin
        #1;
        check("rst_busy", {31'b0, busy}, 32'd0);
        check("rst_done", {31'b0, done}, 32'd0);
        check("rst_quotient", quotient, 32'd0);
        check("rst_remainder", remainder, 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // 100/7 with busy window checks; now in cycle 1 after issue returns
        issue(32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 34, 1'b1);
        check("busy_c1", {31'b0, busy}, 32'd1);
        repeat (33) @(negedge clk);
        check("busy_c34", {31'b0, busy}, 32'd1);
        check("done_c34", {31'b0, done}, 32'd1);
        @(negedge clk);
        check("busy_c35", {31'b0, busy}, 32'd0);
        check("done_c35", {31'b0, done}, 32'd0);

        div(32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 32'd0);
        div(32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1, 32'd0);
        div(32'd1000000, 32'd3, 32'd333333, 32'd1);
        div(32'h8000_0000, 32'h0001_0000, 32'h0000_8000, 32'd0);
        div(32'd0, 32'd5, 32'd0, 32'd0);
        div(32'hDEAD_BEEF, 32'd16, 32'h0DEA_DBEE, 32'hF);

        // Divide by zero: done in cycle 1
        issue(32'd5, 32'd0, 32'hFFFF_FFFF, 32'd5, 1'b1, 1, 1'b1);
        wait_idle();
        div(32'd7, 32'd7, 32'd1, 32'd0);

        // 3/10 with a start pulse placed in the DONE cycle
        issue(32'd3, 32'd10, 32'd0, 32'd3, 1'b0, 34, 1'b1);
        for (int i = 0; i < 60; i++) begin
            if (done) break;
            @(negedge clk);
        end
        check("done_seen_3_10", {31'b0, done}, 32'd1);
        dividend = 32'd7;
        divisor  = 32'd3;
        start    = 1'b1;
        @(negedge clk);
        start    = 1'b0;
        check("start_in_done_ignored", {31'b0, busy}, 32'd0);
        repeat (40) @(negedge clk);

        // Start pulse with 9/2 in cycle 5 of a running 100/7
        issue(32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 34, 1'b1);
        repeat (4) @(negedge clk);
        dividend = 32'd9;
        divisor  = 32'd2;
        start    = 1'b1;
        @(negedge clk);
        start    = 1'b0;
        wait_idle();
        repeat (40) @(negedge clk);
        check("hold_quotient", quotient, 32'd14);
        check("hold_remainder", remainder, 32'd2);

        // Reset in cycle 10 of 100/7: no result expected
        issue(32'd100, 32'd7, 32'd0, 32'd0, 1'b0, 34, 1'b0);
        repeat (9) @(negedge clk);
        rst = 1'b1;
        #1;
        check("midrst_busy", {31'b0, busy}, 32'd0);
        check("midrst_done", {31'b0, done}, 32'd0);
        check("midrst_quotient", quotient, 32'd0);
        check("midrst_remainder", remainder, 32'd0);
        check("midrst_dbz", {31'b0, div_by_zero}, 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (40) @(negedge clk);
        div(32'd50, 32'd6, 32'd8, 32'd2);

        for (int i = 0; i < 100; i++) begin
            if (sb.size() == 0) break;
            @(negedge clk);
        end
        check("scoreboard_drained", sb.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
